// File: rtl/cpu_boot_ctrl.sv
// Boot and self-check controller: streams a program into imem while holding the core
// in reset, then runs the core and compares a watched register against an expected value.
`timescale 1ns/1ps

module cpu_boot_ctrl #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int MAX_CYCLES = 1024,
    parameter int CYC_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [XLEN-1:0]   ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [XLEN-1:0]   exp_data,
    input  logic [XLEN-1:0]   watch_data,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              overflow,
    output logic [CYC_W-1:0]  cycles,
    output logic [ADDR_W:0]   words
);

    typedef enum logic [1:0] {
        LOAD,
        FLUSH,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_W:0]  LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES - 1);

    state_t              r_state;
    logic                r_ldReady;
    logic                r_imemWe;
    logic [ADDR_W-1:0]   r_imemWaddr;
    logic [XLEN-1:0]     r_imemWdata;
    logic                r_coreReset;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic                r_overflow;
    logic [CYC_W-1:0]    r_cycles;
    logic [ADDR_W:0]     r_words;
    logic [XLEN-1:0]     r_expQ;

    logic w_handshake;
    logic w_finalWord;
    logic w_match;
    logic w_cycLimit;

    // The final word is either flagged by the source or the one that fills imem.
    assign w_handshake = ld_valid & r_ldReady & (r_state == LOAD);
    assign w_finalWord = ld_last | (r_words == LAST_IDX);
    assign w_match     = (watch_data == r_expQ);
    assign w_cycLimit  = (r_cycles == CYC_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= LOAD;
            r_ldReady   <= 1'b0;
            r_imemWe    <= 1'b0;
            r_imemWaddr <= '0;
            r_imemWdata <= '0;
            r_coreReset <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_cycles    <= '0;
            r_words     <= '0;
            r_expQ      <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_imemWe  <= w_handshake;
                    r_ldReady <= ~(w_handshake & w_finalWord);
                    if (w_handshake) begin
                        r_imemWaddr <= r_words[ADDR_W-1:0];
                        r_imemWdata <= ld_data;
                        r_words     <= r_words + (ADDR_W+1)'(1);
                        if (w_finalWord) begin
                            r_expQ     <= exp_data;
                            r_overflow <= ~ld_last;
                            r_state    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    r_imemWe    <= 1'b0;
                    r_coreReset <= 1'b0;
                    r_state     <= RUN;
                end
                // A match on the final budget cycle still counts as a pass.
                RUN: begin
                    r_cycles <= r_cycles + CYC_W'(1);
                    if (w_match) begin
                        r_pass      <= ~r_overflow;
                        r_done      <= 1'b1;
                        r_coreReset <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_cycLimit) begin
                        r_timeout   <= 1'b1;
                        r_done      <= 1'b1;
                        r_coreReset <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (restart) begin
                        r_words    <= '0;
                        r_cycles   <= '0;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_overflow <= 1'b0;
                        r_ldReady  <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign ld_ready   = r_ldReady;
    assign imem_we    = r_imemWe;
    assign imem_waddr = r_imemWaddr;
    assign imem_wdata = r_imemWdata;
    assign core_reset = r_coreReset;
    assign done       = r_done;
    assign pass       = r_pass;
    assign timeout    = r_timeout;
    assign overflow   = r_overflow;
    assign cycles     = r_cycles;
    assign words      = r_words;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Scoreboard bench for cpu_boot_ctrl: stimulus pushes expected imem writes and
// end-of-test results into queues; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_cpu_boot_ctrl;

    localparam int XLEN       = 32;
    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 2;
    localparam int MAX_CYCLES = 8;
    localparam int CYC_W      = 16;
    localparam logic [XLEN-1:0] NOMATCH = 32'hFFFF_FFFF;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid;
    logic [XLEN-1:0]   ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic [XLEN-1:0]   exp_data;
    logic [XLEN-1:0]   watch_data;
    logic              restart;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [XLEN-1:0]   imem_wdata;
    logic              core_reset;
    logic              done;
    logic              pass;
    logic              timeout;
    logic              overflow;
    logic [CYC_W-1:0]  cycles;
    logic [ADDR_W:0]   words;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } wrExp_t;

    typedef struct {
        logic             pass;
        logic             timeout;
        logic             overflow;
        logic [CYC_W-1:0] cycles;
        logic [ADDR_W:0]  words;
    } doneExp_t;

    wrExp_t   writeQ[$];
    doneExp_t doneQ[$];

    int              compared   = 0;
    int              mismatched = 0;
    logic [ADDR_W:0] modelWords = '0;
    logic            prevDone   = 1'b0;

    cpu_boot_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .MAX_CYCLES(MAX_CYCLES), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .exp_data(exp_data), .watch_data(watch_data), .restart(restart),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .done(done), .pass(pass), .timeout(timeout),
        .overflow(overflow), .cycles(cycles), .words(words)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic flagUnexpected(input string name, input logic [63:0] actual);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got %0h, expected no event", name, actual);
    endtask

    // Offers one word and waits (bounded) for the handshake edge.
    task automatic applyStimulus(input logic [XLEN-1:0] data, input logic last, input logic [XLEN-1:0] expv);
        int n = 0;
        wrExp_t e;
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        exp_data = expv;
        while (ld_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("ldReadyWait", ld_ready, 1);
        if (ld_ready === 1'b1) begin
            e.addr = modelWords[ADDR_W-1:0];
            e.data = data;
            writeQ.push_back(e);
            modelWords = modelWords + 1'b1;
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
    endtask

    task automatic pushDone(input logic p, input logic t, input logic o, input int c, input int w);
        doneExp_t d;
        d.pass     = p;
        d.timeout  = t;
        d.overflow = o;
        d.cycles   = CYC_W'(c);
        d.words    = (ADDR_W+1)'(w);
        doneQ.push_back(d);
    endtask

    // Called right after the last handshake edge: checks FLUSH, then steps into RUN cycle 0.
    task automatic enterRun();
        checkOutput("flushCoreReset", core_reset, 1);
        checkOutput("flushLdReady", ld_ready, 0);
        idleCycle();
        checkOutput("runCoreReset", core_reset, 0);
    endtask

    task automatic waitDone();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            idleCycle();
            n++;
        end
        checkOutput("doneReached", done, 1);
    endtask

    task automatic matchAt(input int k, input logic [XLEN-1:0] value);
        repeat (k) idleCycle();
        watch_data = value;
        waitDone();
        watch_data = NOMATCH;
    endtask

    task automatic doRestart();
        restart = 1'b1;
        idleCycle();
        restart = 1'b0;
        modelWords = '0;
        checkOutput("restartLdReady", ld_ready, 1);
        checkOutput("restartDone", done, 0);
        checkOutput("restartPass", pass, 0);
        checkOutput("restartTimeout", timeout, 0);
        checkOutput("restartOverflow", overflow, 0);
        checkOutput("restartWords", words, 0);
        checkOutput("restartCycles", cycles, 0);
        checkOutput("restartCoreReset", core_reset, 1);
    endtask

    // Monitor: every imem write and every rising done is matched against the scoreboard.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (writeQ.size() == 0) begin
                flagUnexpected("unexpectedWrite", {32'(imem_waddr), imem_wdata});
            end else begin
                wrExp_t e;
                e = writeQ.pop_front();
                checkOutput("writeAddr", imem_waddr, e.addr);
                checkOutput("writeData", imem_wdata, e.data);
            end
        end
        if (done === 1'b1 && prevDone !== 1'b1) begin
            if (doneQ.size() == 0) begin
                flagUnexpected("unexpectedDone", cycles);
            end else begin
                doneExp_t d;
                d = doneQ.pop_front();
                checkOutput("donePass", pass, d.pass);
                checkOutput("doneTimeout", timeout, d.timeout);
                checkOutput("doneOverflow", overflow, d.overflow);
                checkOutput("doneCycles", cycles, d.cycles);
                checkOutput("doneWords", words, d.words);
                checkOutput("doneCoreReset", core_reset, 1);
            end
        end
        prevDone = done;
    end

    initial begin
        reset      = 1'b1;
        ld_valid   = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        exp_data   = '0;
        watch_data = NOMATCH;
        restart    = 1'b0;

        repeat (2) idleCycle();
        checkOutput("rstLdReady", ld_ready, 0);
        checkOutput("rstCoreReset", core_reset, 1);
        checkOutput("rstDone", done, 0);
        checkOutput("rstImemWe", imem_we, 0);
        checkOutput("rstWords", words, 0);
        checkOutput("rstCycles", cycles, 0);
        @(negedge clk) reset = 1'b0;
        checkOutput("readyBeforeEdge", ld_ready, 0);
        idleCycle();
        checkOutput("readyAfterRelease", ld_ready, 1);

        $display("[TB] basic program");
        applyStimulus(32'h00100093, 1'b0, 32'd2);
        applyStimulus(32'h00100113, 1'b0, 32'd2);
        applyStimulus(32'h002081B3, 1'b1, 32'd2);
        enterRun();
        pushDone(1'b1, 1'b0, 1'b0, 4, 3);
        matchAt(3, 32'd2);
        repeat (2) idleCycle();
        checkOutput("cyclesFrozen", cycles, 4);

        $display("[TB] backpressure with gaps, restart ignored in RUN");
        doRestart();
        applyStimulus(32'h11111111, 1'b0, 32'd9);
        idleCycle();
        applyStimulus(32'h22222222, 1'b0, 32'd9);
        idleCycle();
        applyStimulus(32'h33333333, 1'b1, 32'd9);
        enterRun();
        pushDone(1'b1, 1'b0, 1'b0, 2, 3);
        restart = 1'b1;
        idleCycle();
        restart = 1'b0;
        checkOutput("restartInRunIgnored", core_reset, 0);
        matchAt(0, 32'd9);

        $display("[TB] timeout");
        doRestart();
        applyStimulus(32'hAAAA0000, 1'b0, 32'd5);
        applyStimulus(32'hAAAA0001, 1'b1, 32'd5);
        watch_data = 32'd0;
        enterRun();
        pushDone(1'b0, 1'b1, 1'b0, 8, 2);
        repeat (7) idleCycle();
        checkOutput("doneBeforeBudget", done, 0);
        idleCycle();
        checkOutput("doneAtBudget", done, 1);
        watch_data = NOMATCH;

        $display("[TB] match on the timeout cycle");
        doRestart();
        applyStimulus(32'hCAFE0001, 1'b1, 32'hA5A50001);
        enterRun();
        pushDone(1'b1, 1'b0, 1'b0, 8, 1);
        matchAt(7, 32'hA5A50001);

        $display("[TB] overflow");
        doRestart();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(32'hD0000000 + 32'(i), 1'b0, 32'd7);
        end
        ld_valid = 1'b1;
        ld_data  = 32'hBAD0BAD0;
        ld_last  = 1'b0;
        enterRun();
        checkOutput("ovfReadyInRun", ld_ready, 0);
        pushDone(1'b0, 1'b0, 1'b1, 1, 4);
        matchAt(0, 32'd7);
        ld_valid = 1'b0;

        $display("[TB] async reset mid-run");
        doRestart();
        applyStimulus(32'hEEEE0001, 1'b1, 32'd3);
        enterRun();
        repeat (2) idleCycle();
        reset = 1'b1;
        #1;
        modelWords = '0;
        checkOutput("midRstCoreReset", core_reset, 1);
        checkOutput("midRstDone", done, 0);
        checkOutput("midRstTimeout", timeout, 0);
        checkOutput("midRstOverflow", overflow, 0);
        checkOutput("midRstLdReady", ld_ready, 0);
        checkOutput("midRstCycles", cycles, 0);
        checkOutput("midRstWords", words, 0);
        @(negedge clk) reset = 1'b0;
        checkOutput("midRstReadyBeforeEdge", ld_ready, 0);
        idleCycle();
        checkOutput("midRstReadyAfterEdge", ld_ready, 1);

        $display("[TB] load after reset");
        applyStimulus(32'h0F0F0F0F, 1'b0, 32'd8);
        applyStimulus(32'hF0F0F0F0, 1'b1, 32'd8);
        enterRun();
        pushDone(1'b1, 1'b0, 1'b0, 1, 2);
        matchAt(0, 32'd8);

        repeat (2) idleCycle();
        checkOutput("writeQueueDrained", writeQ.size(), 0);
        checkOutput("doneQueueDrained", doneQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
